// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage enable/flush generation for bus waits, load-use,
// multi-cycle mul/div occupancy and branch redirects. Optional macro HAZARD_PERF_EN adds stall/flush counters.
module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wait,
  input  logic        d_wait,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  e_dst,
  input  logic        e_is_load,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        branch_taken,
  output logic        en_pc,
  output logic        en_d,
  output logic        en_e,
  output logic        en_m,
  output logic        en_w,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic        md_busy,
  output logic        md_done,
  output logic        discard_fetch,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic             MUL_MULTI = (MUL_LAT > 1);
  localparam logic             DIV_MULTI = (DIV_LAT > 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             disc_reg, disc_next;
  logic             md_first, lat_multi, load_use, branch_act;

  always_comb begin
    md_first   = md_start && (cnt_reg == '0);
    lat_multi  = md_is_div ? DIV_MULTI : MUL_MULTI;
    load_use   = e_is_load && (e_dst != 5'd0) && ((e_dst == ra1) || (e_dst == ra2));
    md_busy    = (cnt_reg > CNT_W'(1)) || (md_first && lat_multi);
    md_done    = (cnt_reg == CNT_W'(1)) || (md_first && !lat_multi);
    branch_act = 1'b0;

    en_pc   = 1'b1;
    en_d    = 1'b1;
    en_e    = 1'b1;
    en_m    = 1'b1;
    en_w    = 1'b1;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;

    if (d_wait) begin
      en_pc   = 1'b0;
      en_d    = 1'b0;
      en_e    = 1'b0;
      en_m    = 1'b0;
      flush_w = 1'b1;
    end else if (md_busy) begin
      en_pc   = 1'b0;
      en_d    = 1'b0;
      en_e    = 1'b0;
      flush_m = 1'b1;
    end else if (branch_taken) begin
      // The redirect wins over load-use (the hazarding instruction is flushed)
      // and keeps the PC loading the target even while a fetch is outstanding.
      branch_act = 1'b1;
      flush_d    = 1'b1;
      flush_e    = 1'b1;
    end else if (load_use) begin
      en_pc   = 1'b0;
      en_d    = 1'b0;
      flush_e = 1'b1;
    end else if (i_wait || disc_reg) begin
      en_pc   = 1'b0;
      flush_d = 1'b1;
    end

    discard_fetch = disc_reg;
    disc_next     = (disc_reg && i_wait) || (branch_act && (i_wait || disc_reg));

    // A held md_start while counting is the same instruction, so it is ignored.
    if (md_first)
      cnt_next = md_is_div ? DIV_LOAD : MUL_LOAD;
    else if ((cnt_reg != '0) && !d_wait)
      cnt_next = cnt_reg - CNT_W'(1);
    else
      cnt_next = cnt_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      disc_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      disc_reg <= disc_next;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!en_pc)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (flush_d || flush_e)
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule
